seq_detector_param: RTL and testbench



---
 rtl/seq_det_pkg.sv | 13 +
 rtl/sat_counter.sv | 22 ++
 rtl/seq_detector_param.sv | 85 ++++++++
 tb/tb_seq_detector_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial pattern detector: default
// geometry and the overlap mode encoding used by the top level and benches.
package seq_det_pkg;

  localparam int              DEF_N             = 4;
  localparam int              DEF_CNT_W         = 8;
  localparam logic [DEF_N-1:0] DEF_RESET_PATTERN = 4'b0110;

  // Value of the overlap input selecting each detection mode.
  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
// Synchronous active-high reset; clear has the same effect as reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial pattern detector. Keeps the last N-1 accepted
// bits plus a fill count; a match is flagged combinationally in the cycle
// the final bit is presented. Supports run-time pattern loading, overlapping
// or non-overlapping detection, a registered match copy and a saturating
// match counter.
//
// Input qualification: a bit on x is consumed on a rising clk edge only when
// en=1, pat_load=0 and reset=0. There is no back-pressure; every accepted
// bit is consumed. Priority is reset > pat_load > en.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int           N             = DEF_N,
  parameter logic [N-1:0] RESET_PATTERN = DEF_RESET_PATTERN,
  parameter int           CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_count,
  output logic [N-1:0]     pattern
);

  localparam int             FW       = $clog2(N);
  localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

  logic [N-2:0]  hist;    // last N-1 accepted bits, newest in bit 0
  logic [FW-1:0] fill;    // number of valid history bits, saturates at N-1
  logic [N-1:0]  window;  // history extended with the bit currently on x
  logic          accept;
  logic          full;
  logic          match;

  assign window = {hist, x};
  assign accept = en & ~pat_load & ~reset;
  assign full   = (fill == FILL_MAX);
  assign match  = accept & full & (window == pattern);
  assign z      = match;

  // History, fill, active pattern and the registered match copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= RESET_PATTERN;
      z_q     <= 1'b0;
    end else begin
      z_q <= match;
      if (pat_load) begin
        // New pattern: discard any partial match built on the old one.
        pattern <= pat_in;
        hist    <= '0;
        fill    <= '0;
      end else if (accept) begin
        if (match && (overlap == NON_OVERLAP)) begin
          // Non-overlapping: the next match must be built from fresh bits.
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= window[N-2:0];
          if (!full) begin
            fill <= fill + 1'b1;
          end
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (match),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Two instances share one stimulus stream:
// dut_a with an 8-bit counter and dut_b with a 2-bit counter so that
// counter saturation is observed on the same traffic. A queue-based model
// of the accepted bit stream predicts every output each cycle; directed
// streams also carry hand-computed z values and counter totals.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset / stimulus signals ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         x;
  logic         overlap;
  logic         pat_load;
  logic [N-1:0] pat_in;

  logic         z_a, zq_a, z_b, zq_b;
  logic [7:0]   count_a;
  logic [1:0]   count_b;
  logic [N-1:0] pattern_a, pattern_b;

  always #5 clk = ~clk;

  seq_detector_param #(.N(N), .RESET_PATTERN(4'b0110), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .z(z_a), .z_q(zq_a),
    .match_count(count_a), .pattern(pattern_a)
  );

  seq_detector_param #(.N(N), .RESET_PATTERN(4'b0110), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .z(z_b), .z_q(zq_b),
    .match_count(count_b), .pattern(pattern_b)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model remembers the accepted bits since the last clear (at most the
  // newest N-1), the active pattern, a match total and the previous z.
  logic         hq[$];
  logic [N-1:0] mpat;
  int           mcount;
  logic         mzq;
  logic         mvalid = 1'b0;
  logic         ez_pos;
  logic         ez_neg;

  function automatic logic model_z();
    logic [N-1:0] w;
    if (reset || pat_load || !en) return 1'b0;
    if (hq.size() < N - 1) return 1'b0;
    for (int i = 0; i < N - 1; i++) w[N-1-i] = hq[i];
    w[0] = x;
    return (w == mpat);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hq.delete();
      mpat   = 4'b0110;
      mzq    = 1'b0;
      mcount = 0;
      mvalid = 1'b1;
    end else begin
      ez_pos = model_z();
      mzq    = ez_pos;
      if (pat_load) begin
        mpat = pat_in;
        hq.delete();
      end else if (en) begin
        if (ez_pos) mcount++;
        if (ez_pos && (overlap == NON_OVERLAP)) begin
          hq.delete();
        end else begin
          hq.push_back(x);
          if (hq.size() > N - 1) void'(hq.pop_front());
        end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (mvalid) begin
      ez_neg = model_z();
      check("z_a",       {31'd0, z_a},  {31'd0, ez_neg});
      check("z_b",       {31'd0, z_b},  {31'd0, ez_neg});
      check("z_q_a",     {31'd0, zq_a}, {31'd0, mzq});
      check("z_q_b",     {31'd0, zq_b}, {31'd0, mzq});
      check("count_a",   {24'd0, count_a}, sat(mcount, 255));
      check("count_b",   {30'd0, count_b}, sat(mcount, 3));
      check("pattern_a", {28'd0, pattern_a}, {28'd0, mpat});
      check("pattern_b", {28'd0, pattern_b}, {28'd0, mpat});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; en = 1'b0; x = 1'b0; pat_load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Present one bit for one cycle and hand-check z before the edge.
  task automatic send(input logic e, input logic b, input logic exp_z, input string nm);
    en = e; x = b;
    #1;
    check(nm, {31'd0, z_a}, {31'd0, exp_z});
    @(posedge clk); #1;
    en = 1'b0; x = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input logic [15:0] zexp,
                           input int len, input string nm);
    for (int i = len - 1; i >= 0; i--) send(1'b1, bits[i], zexp[i], nm);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; en = 1'b0; x = 1'b0; overlap = OVERLAP;
    pat_load = 1'b0; pat_in = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset state.
    check("rst_count",   {24'd0, count_a}, 0);
    check("rst_pattern", {28'd0, pattern_a}, 32'h6);
    check("rst_z_q",     {31'd0, zq_a}, 0);

    // Overlap: 0110110 -> z on bits 4 and 7.
    overlap = OVERLAP;
    send_bits(16'b0110110, 16'b0001001, 7, "ovl_z");
    check("ovl_z_q",   {31'd0, zq_a}, 1);
    check("ovl_count", {24'd0, count_a}, 2);

    // Non-overlap: same stream -> z on bit 4 only; then 110 completes 0110
    // from bits 7..10, all taken after the clear.
    do_reset();
    overlap = NON_OVERLAP;
    send_bits(16'b0110110, 16'b0001000, 7, "novl_z");
    check("novl_count", {24'd0, count_a}, 1);
    send_bits(16'b110, 16'b001, 3, "novl_tail_z");
    check("novl_count2", {24'd0, count_a}, 2);

    // Enable gaps do not break a partial match.
    do_reset();
    overlap = OVERLAP;
    send(1'b1, 1'b0, 1'b0, "gap_z");
    send(1'b1, 1'b1, 1'b0, "gap_z");
    send(1'b0, 1'b1, 1'b0, "gap_off_z");
    send(1'b0, 1'b0, 1'b0, "gap_off_z");
    send(1'b0, 1'b1, 1'b0, "gap_off_z");
    send(1'b1, 1'b1, 1'b0, "gap_z");
    send(1'b1, 1'b0, 1'b1, "gap_z");
    check("gap_count", {24'd0, count_a}, 1);

    // Reset in the middle of a partial match.
    do_reset();
    send_bits(16'b011, 16'b000, 3, "rmid_z");
    reset = 1'b1; en = 1'b1; x = 1'b0;
    #1;
    check("rmid_z_in_reset", {31'd0, z_a}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send(1'b1, 1'b0, 1'b0, "rmid_after_z");
    check("rmid_count", {24'd0, count_a}, 0);
    send_bits(16'b0110, 16'b0001, 4, "rmid_fresh_z");
    check("rmid_count2", {24'd0, count_a}, 1);

    // Pattern load discards x and history, keeps the counter.
    do_reset();
    overlap = OVERLAP;
    send_bits(16'b011011, 16'b000100, 6, "load_pre_z");
    pat_load = 1'b1; pat_in = 4'b1011; en = 1'b1; x = 1'b0;
    #1;
    check("load_z", {31'd0, z_a}, 0);
    @(posedge clk); #1;
    pat_load = 1'b0; en = 1'b0;
    check("load_pattern", {28'd0, pattern_a}, 32'hB);
    check("load_count",   {24'd0, count_a}, 1);
    check("load_z_q",     {31'd0, zq_a}, 0);
    send_bits(16'b1011011, 16'b0001001, 7, "load_new_z");
    check("load_count2", {24'd0, count_a}, 3);

    // Saturation on the 2-bit counter: four overlapping matches.
    do_reset();
    overlap = OVERLAP;
    send_bits(16'b0110110110110, 16'b0001001001001, 13, "sat_z");
    check("sat_count_b", {30'd0, count_b}, 3);
    check("sat_count_a", {24'd0, count_a}, 4);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
